// File: rtl/linebuffer_window9_pkg.sv
// rtl/linebuffer_window9_pkg.sv - shared window geometry constants and element indexing
package lb_pkg;

    localparam int PIX_W     = 7;
    localparam int K         = 9;
    localparam int WIN_ELEMS = K * K;
    localparam int WIN_W     = WIN_ELEMS * PIX_W;

    // Flat element index of window row r (0 = oldest) and column c (0 = oldest).
    function automatic int win_index(input int r, input int c);
        return r * K + c;
    endfunction

endpackage

// File: rtl/linebuffer_window9_if.sv
// rtl/linebuffer_window9_if.sv - pixel stream in, flat window out
interface linebuffer_window9_if #(
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) ();
    import lb_pkg::*;

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    logic [PIX_W-1:0] pix_in;
    logic             pix_valid;
    logic             sof;
    logic [WIN_W-1:0] win_out;
    logic             win_valid;
    logic [ROW_W-1:0] win_row;
    logic [COL_W-1:0] win_col;
    logic             eof;

    // Pixel source / window consumer side.
    modport master (
        output pix_in, pix_valid, sof,
        input  win_out, win_valid, win_row, win_col, eof
    );

    // Line buffer side.
    modport slave (
        input  pix_in, pix_valid, sof,
        output win_out, win_valid, win_row, win_col, eof
    );
endinterface

// File: rtl/linebuffer_window9_line_delay.sv
// rtl/linebuffer_window9_line_delay.sv - enable-gated circular-RAM delay of DEPTH accepted samples
module line_delay #(
    parameter int DEPTH = 28,
    parameter int W     = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Slot at the pointer holds the sample written DEPTH accepts ago; it is read before being overwritten.
    assign dout = mem[ptr_q];

    // Advance the circular pointer on each accepted sample.
    always_comb begin
        ptr_d = ptr_q;
        if (en) begin
            ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Storage is left unreset; downstream validity gating hides stale contents.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr_q] <= din;
        end
    end
endmodule

// File: rtl/linebuffer_window9.sv
// rtl/linebuffer_window9.sv - 8-row line buffer feeding a 9x9 sliding pixel window
module linebuffer_window9
    import lb_pkg::*;
#(
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) (
    input  logic                 clk,
    input  logic                 rst_n,
    linebuffer_window9_if.slave  bus
);
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    logic [COL_W-1:0] col_cnt_q, col_cnt_d, cur_col;
    logic [ROW_W-1:0] row_cnt_q, row_cnt_d, cur_row;
    logic             win_valid_q, win_valid_d;
    logic             eof_q, eof_d;
    logic [ROW_W-1:0] win_row_q, win_row_d;
    logic [COL_W-1:0] win_col_q, win_col_d;
    logic [PIX_W-1:0] win_q [K][K];
    logic [PIX_W-1:0] win_d [K][K];
    logic [PIX_W-1:0] tap   [K];
    logic [WIN_W-1:0] win_flat;

    // Tap K-1 is the live pixel; each delay line pushes a row further into the past.
    assign tap[K-1] = bus.pix_in;

    for (genvar j = 0; j < K - 1; j++) begin : g_rows
        line_delay #(.DEPTH(IMG_WIDTH), .W(PIX_W)) u_line (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (bus.pix_valid),
            .din  (tap[j+1]),
            .dout (tap[j])
        );
    end

    // Position tracking, window validity and the registered output strobes.
    always_comb begin
        cur_col     = bus.sof ? '0 : col_cnt_q;
        cur_row     = bus.sof ? '0 : row_cnt_q;
        col_cnt_d   = col_cnt_q;
        row_cnt_d   = row_cnt_q;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
        win_valid_d = 1'b0;
        eof_d       = 1'b0;
        if (bus.pix_valid) begin
            if (cur_col == COL_W'(IMG_WIDTH - 1)) begin
                col_cnt_d = '0;
                row_cnt_d = (cur_row == ROW_W'(IMG_HEIGHT - 1)) ? '0 : cur_row + 1'b1;
            end else begin
                col_cnt_d = cur_col + 1'b1;
                row_cnt_d = cur_row;
            end
            // col >= K-1 keeps every window inside the current rows, so no row-wrap straddling.
            if (cur_row >= ROW_W'(K - 1) && cur_col >= COL_W'(K - 1)) begin
                win_valid_d = 1'b1;
                win_row_d   = cur_row - ROW_W'(K - 1);
                win_col_d   = cur_col - COL_W'(K - 1);
            end
            eof_d = (cur_row == ROW_W'(IMG_HEIGHT - 1)) && (cur_col == COL_W'(IMG_WIDTH - 1));
        end
    end

    // Shift every window row left and load the newest column from the row taps.
    always_comb begin
        win_d = win_q;
        if (bus.pix_valid) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][K-1] = tap[r];
            end
        end
    end

    // Counter, strobe and window state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt_q   <= '0;
            row_cnt_q   <= '0;
            win_valid_q <= 1'b0;
            eof_q       <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            col_cnt_q   <= col_cnt_d;
            row_cnt_q   <= row_cnt_d;
            win_valid_q <= win_valid_d;
            eof_q       <= eof_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
            win_q       <= win_d;
        end
    end

    // Flatten the window registers into the packed output vector.
    always_comb begin
        win_flat = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                win_flat[win_index(r, c)*PIX_W +: PIX_W] = win_q[r][c];
            end
        end
    end

    assign bus.win_out   = win_flat;
    assign bus.win_valid = win_valid_q;
    assign bus.win_row   = win_row_q;
    assign bus.win_col   = win_col_q;
    assign bus.eof       = eof_q;
endmodule

// File: tb/tb_linebuffer_window9.sv
// tb/tb_linebuffer_window9.sv - self-checking bench for linebuffer_window9
module tb_linebuffer_window9;
    import lb_pkg::*;

    localparam int W = 28;
    localparam int H = 28;

    typedef struct {
        int r; int c;
        bit v; bit e; bit d;
        int wr; int wc;
        int e0; int e8; int e72; int e80;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    linebuffer_window9_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) bus ();
    linebuffer_window9 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int tests = 0;
    int fails = 0;
    int m_row, m_col, exp_row, exp_col, nstrobe;
    logic [PIX_W-1:0] img [H][W];
    logic [WIN_W-1:0] exp_win;
    bit exp_known;
    bit cap_armed;
    int cap_e0, cap_e80;
    vec_t tbl [9];

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_win(input string name, input logic [WIN_W-1:0] act, input logic [WIN_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int elem(input logic [WIN_W-1:0] w, input int e);
        return int'(w[e*PIX_W +: PIX_W]);
    endfunction

    function automatic logic [PIX_W-1:0] ramp(input int r, input int c, input int off);
        return PIX_W'((r * W + c + off) % 128);
    endfunction

    task automatic model_reset();
        m_row = 0; m_col = 0; exp_row = 0; exp_col = 0;
        exp_win = '0; exp_known = 1'b1;
    endtask

    // Apply one cycle and compare against the frame-image reference model.
    task automatic drive(input logic [PIX_W-1:0] p, input bit v, input bit s);
        int r, c;
        bit ev, ee;
        @(negedge clk);
        bus.pix_in = p; bus.pix_valid = v; bus.sof = s;
        @(posedge clk);
        #1;
        ev = 1'b0; ee = 1'b0;
        if (v) begin
            r = s ? 0 : m_row;
            c = s ? 0 : m_col;
            img[r][c] = p;
            ev = (r >= K - 1) && (c >= K - 1);
            ee = (r == H - 1) && (c == W - 1);
            exp_known = ev;
            if (ev) begin
                exp_row = r - (K - 1);
                exp_col = c - (K - 1);
                for (int i = 0; i < K; i++)
                    for (int j = 0; j < K; j++)
                        exp_win[(i*K+j)*PIX_W +: PIX_W] = img[r-(K-1)+i][c-(K-1)+j];
            end
            m_row = (c == W - 1) ? (r + 1) % H : r;
            m_col = (c + 1) % W;
        end
        chk("win_valid", bus.win_valid, ev);
        chk("eof", bus.eof, ee);
        chk("win_row", bus.win_row, exp_row);
        chk("win_col", bus.win_col, exp_col);
        if (exp_known) chk_win("win_out", bus.win_out, exp_win);
        if (bus.win_valid) begin
            nstrobe++;
            if (cap_armed) begin
                cap_e0 = elem(bus.win_out, 0);
                cap_e80 = elem(bus.win_out, 80);
                cap_armed = 1'b0;
            end
        end
    endtask

    task automatic send_frame(input int off, input bit gaps, input bit first_sof, input int npix);
        for (int n = 0; n < npix; n++) begin
            if (gaps)
                for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++)
                    drive(PIX_W'($urandom), 1'b0, 1'($urandom));
            drive(ramp(n / W, n % W, off), 1'b1, first_sof && n == 0);
        end
    endtask

    initial begin
        int idx;
        int v;
        tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{8, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[2] = '{8, 8, 1, 0, 1, 0, 0, 0, 8, 96, 104};
        tbl[3] = '{8, 27, 1, 0, 1, 0, 19, 19, 27, 115, 123};
        tbl[4] = '{9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[5] = '{9, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[6] = '{9, 8, 1, 0, 1, 1, 0, 28, 36, 124, 4};
        tbl[7] = '{27, 26, 1, 0, 1, 19, 18, 38, 46, 6, 14};
        tbl[8] = '{27, 27, 1, 1, 1, 19, 19, 39, 47, 7, 15};

        bus.pix_in = '0; bus.pix_valid = 1'b0; bus.sof = 1'b0;
        cap_armed = 1'b0; cap_e0 = -1; cap_e80 = -1; nstrobe = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_win("reset_win_out", bus.win_out, '0);
        chk("reset_win_valid", bus.win_valid, 0);
        chk("reset_eof", bus.eof, 0);
        chk("reset_win_row", bus.win_row, 0);
        chk("reset_win_col", bus.win_col, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Ramp frame with table-driven checkpoints.
        idx = 0; nstrobe = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                drive(ramp(r, c, 0), 1'b1, r == 0 && c == 0);
                if (idx < 9 && tbl[idx].r == r && tbl[idx].c == c) begin
                    chk("tbl_valid", bus.win_valid, tbl[idx].v);
                    chk("tbl_eof", bus.eof, tbl[idx].e);
                    if (tbl[idx].d) begin
                        chk("tbl_win_row", bus.win_row, tbl[idx].wr);
                        chk("tbl_win_col", bus.win_col, tbl[idx].wc);
                        chk("tbl_e0", elem(bus.win_out, 0), tbl[idx].e0);
                        chk("tbl_e8", elem(bus.win_out, 8), tbl[idx].e8);
                        chk("tbl_e72", elem(bus.win_out, 72), tbl[idx].e72);
                        chk("tbl_e80", elem(bus.win_out, 80), tbl[idx].e80);
                    end
                    idx++;
                end
            end
        end
        chk("tbl_entries_hit", idx, 9);
        chk("ramp_strobes", nstrobe, 400);

        // Same frame with random valid gaps.
        nstrobe = 0;
        send_frame(0, 1'b1, 1'b1, W * H);
        chk("gap_strobes", nstrobe, 400);

        // Two back-to-back frames; the second relies on counter wrap instead of sof.
        nstrobe = 0;
        send_frame(0, 1'b0, 1'b1, W * H);
        cap_armed = 1'b1; cap_e0 = -1; cap_e80 = -1;
        send_frame(50, 1'b0, 1'b0, W * H);
        chk("b2b_strobes", nstrobe, 800);
        chk("b2b_first_e0", cap_e0, 50);
        chk("b2b_first_e80", cap_e80, 26);

        // sof reasserted at pixel (12,5).
        send_frame(0, 1'b0, 1'b1, 12 * W + 5);
        v = $urandom_range(0, 127);
        nstrobe = 0;
        cap_armed = 1'b1; cap_e0 = -1; cap_e80 = -1;
        send_frame(v, 1'b0, 1'b1, W * H);
        chk("midsof_first_e0", cap_e0, v);
        chk("midsof_strobes", nstrobe, 400);

        // Asynchronous reset between edges while a window is valid.
        send_frame(0, 1'b0, 1'b1, 9 * W + 12);
        @(negedge clk);
        bus.pix_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_win("async_rst_win_out", bus.win_out, '0);
        chk("async_rst_win_valid", bus.win_valid, 0);
        chk("async_rst_eof", bus.eof, 0);
        chk("async_rst_win_row", bus.win_row, 0);
        chk("async_rst_win_col", bus.win_col, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        nstrobe = 0;
        cap_armed = 1'b1; cap_e0 = -1; cap_e80 = -1;
        send_frame(0, 1'b0, 1'b1, W * H);
        chk("post_rst_e0", cap_e0, 0);
        chk("post_rst_e80", cap_e80, 104);
        chk("post_rst_strobes", nstrobe, 400);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
